seg_display_driver: RTL and testbench
=====================================

# seg_display_driver

Drives the four-digit, common-anode seven-segment display from the reaction-game control outputs (`select`, `mode`, `number`). It converts the 14-bit binary `number` to BCD with a free-running sequential double-dabble converter. It time-multiplexes the four digits and renders the per-phase content: the mode letter, the target or running count, and the blinking result. It sits between the game controller and the board's `seg`/`an`/`dp` pins.

## Interface
- `REFRESH_TICKS`, default 100000: clk cycles each digit stays selected (1 kHz per digit at 100 MHz).
- `BLINK_TICKS`, default 25000000: clk cycles per blink half-period in the result phase.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `select` in 2: game phase. 0 = mode pick, 1 = running, 2 = result, 3 = target shown.
- `mode` in 2: difficulty. 0 = easy, 1 = regular, 2 = hard.
- `number` in 14: value to display, unsigned binary.
- `seg` out 7: cathodes `{g,f,e,d,c,b,a}`, active-low, registered.
- `dp` out 1: decimal point, active-low; held 1 (off) at all times.
- `an` out 4: anodes, active-low one-hot, registered; `an[0]` is the rightmost digit.

## Operation
- **Converter FSM**, free-running, states LOAD → SHIFT → DONE → LOAD.
  - LOAD (1 cycle): capture `number` into the shift register; clear the 16-bit BCD accumulator.
  - SHIFT (exactly 14 cycles): apply add-3 to every BCD nibble ≥ 5, then shift left 1.
  - DONE (1 cycle): write the four nibbles to the display register atomically. Set `ovf` = (captured value > 9999).
  - Total 16 cycles per conversion. The display register never holds a partial result.
- **Refresh counter**: counts 0..REFRESH_TICKS-1. On wrap, the 2-bit digit index increments mod 4.
- **Digit content**, evaluated for the current index:
  - select 0: digit 0 shows the mode letter: mode 0 `E` (0000110), 1 `n` (0101011), 2 `H` (0001001), 3 dash (0111111). Digits 1-3 are blank (1111111).
  - select 1 or 3: the BCD digit, using decimal glyph codes 0=1000000 … 9=0010000.
    - Leading-zero blanking applies to digits 3..1. Digit 0 always shows, so 0 displays as `0`.
    - If `ovf` is set, all four digits show a dash.
  - select 2: the same as select 1, gated by the blink phase.
- **Blink**:
  - In select 2, the counter runs 0..BLINK_TICKS-1 and the phase toggles on wrap. The phase starts visible on entry to select 2.
  - When the phase is dark, `an` = 1111.
  - Outside select 2, the counter is held at 0 and the phase is held visible. Leaving select 2 restores the display on the next cycle.
- **Outputs**: `an` = ~(1 << index) while not blank-gated; `seg` = the glyph for that index. Both are registered together, so they never mismatch.

## Timing
- **Reset values**: `an` = 1111, `seg` = 1111111, `dp` = 1, index = 0, refresh and blink counters = 0, display register = 0, `ovf` = 0, converter in LOAD.
- **Reset mid-conversion**: the converter aborts and the display register returns to 0.
- **First output after reset release**: the first edge drives `an` = 1110 and `seg` = `0` (for select ≠ 0).
- **Latency**: a change on `number` reaches the display register in ≤ 32 cycles, and reaches the pins ≤ 1 cycle after that if its digit is selected.
- **select/mode changes**: visible on the pins 1 cycle later, because glyph selection is combinational into the output register.
- **Input stability**: `number` may change during SHIFT with no effect until the next LOAD. No handshake is required.
- **Boundary values**: 9999 displays normally; 10000..16383 display `----`.

## Structure
- **Package `seg_pkg`**:
  - Select encodings `SEL_MODE=0`, `SEL_RUN=1`, `SEL_RESULT=2`, `SEL_TARGET=3`.
  - Glyph constants for digits 0-9 and `E`, `n`, `H`, dash, blank.
  - Converter state enum.
- **Sub-module `bin2bcd_seq`**:
  - Ports: `clk`, `rst`, `bin[13:0]`, `bcd[15:0]`, `ovf`, `valid` (1-cycle pulse in DONE).
  - Contains the converter FSM. The top level holds the refresh, blink and glyph/output logic.

## Test plan
Run with REFRESH_TICKS=4 and BLINK_TICKS=16.
- **Reset**: assert `rst` mid-scan and mid-conversion → `an`=1111 and `seg`=1111111 immediately. After release, `an`=1110 and `seg`=1000000.
- **Full scan**: select=1, `number`=1234, wait 32 cycles → the scan shows `an` 1110/1101/1011/0111 with `seg` 0011001/0110000/0100100/1111001, each for 4 cycles.
- **Leading-zero blanking**: select=3, `number`=7 → digit 0 shows 1111000; digits 1-3 show 1111111. `number`=0 → digit 0 shows 1000000.
- **Overflow**: `number`=9999 → shows 9999. `number`=12000 → all digits show 0111111 within 32 cycles.
- **Mode letters**: select=0 with mode 0/1/2/3 → digit 0 shows 0000110/0101011/0001001/0111111; other digits are blank.
- **Blink**: select=2, `number`=42 → 16 cycles scanning, 16 cycles `an`=1111, repeating. Switching to select=0 while dark → `an` is active on the next cycle.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display driver: phase encodings,
// active-low glyph codes ({g,f,e,d,c,b,a}) and the converter state type.
package seg_pkg;

  localparam logic [1:0] SEL_MODE   = 2'd0;
  localparam logic [1:0] SEL_RUN    = 2'd1;
  localparam logic [1:0] SEL_RESULT = 2'd2;
  localparam logic [1:0] SEL_TARGET = 2'd3;

  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_N     = 7'b0101011;
  localparam logic [6:0] GLYPH_H     = 7'b0001001;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    CONV_LOAD,
    CONV_SHIFT,
    CONV_DONE
  } conv_state_t;

  // Decimal digit to glyph; anything above 9 renders blank.
  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  // Double-dabble correction step for one BCD nibble.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Free-running sequential double-dabble converter. One conversion every
// 16 cycles: LOAD captures the input, SHIFT runs 14 add-3/shift steps, DONE
// presents the finished result for one cycle with valid high.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        ovf,
  output logic        valid
);

  conv_state_t state;
  logic [13:0] shift_reg;
  logic [13:0] captured;
  logic [15:0] acc;
  logic [15:0] acc_adj;
  logic [3:0]  step;

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    acc_adj = {add3(acc[15:12]), add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};
  end

  // Converter FSM: LOAD -> SHIFT (14 cycles) -> DONE -> LOAD, forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CONV_LOAD;
      shift_reg <= '0;
      captured  <= '0;
      acc       <= '0;
      step      <= '0;
    end else begin
      case (state)
        CONV_LOAD: begin
          shift_reg <= bin;
          captured  <= bin;
          acc       <= '0;
          step      <= '0;
          state     <= CONV_SHIFT;
        end
        CONV_SHIFT: begin
          acc       <= {acc_adj[14:0], shift_reg[13]};
          shift_reg <= {shift_reg[12:0], 1'b0};
          step      <= step + 4'd1;
          if (step == 4'd13) state <= CONV_DONE;
        end
        CONV_DONE: begin
          state <= CONV_LOAD;
        end
        default: state <= CONV_LOAD;
      endcase
    end
  end

  assign bcd   = acc;
  assign ovf   = (captured > 14'd9999);
  assign valid = (state == CONV_DONE);

endmodule

// File: rtl/seg_display_driver.sv
// Four-digit common-anode display driver: converts the game value to BCD,
// scans the digits, and renders mode letters, counts and the blinking result.
module seg_display_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_TICKS = 100000,
  parameter int BLINK_TICKS   = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  select,
  input  logic [1:0]  mode,
  input  logic [13:0] number,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int RW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [15:0]   conv_bcd;
  logic          conv_ovf;
  logic          conv_valid;
  logic [15:0]   disp;
  logic          disp_ovf;
  logic [RW-1:0] refresh_cnt;
  logic [1:0]    index;
  logic [BW-1:0] blink_cnt;
  logic          blink_dark;
  logic [3:0]    nibble;
  logic          leading_zero;
  logic [6:0]    glyph_next;
  logic [3:0]    an_next;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .bin   (number),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf),
    .valid (conv_valid)
  );

  // Display register: only updated with a completed conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp     <= '0;
      disp_ovf <= 1'b0;
    end else if (conv_valid) begin
      disp     <= conv_bcd;
      disp_ovf <= conv_ovf;
    end
  end

  // Digit scan: advance the digit index each time the refresh counter wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      index       <= 2'd0;
    end else if (refresh_cnt == RW'(REFRESH_TICKS - 1)) begin
      refresh_cnt <= '0;
      index       <= index + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Blink phase runs only in the result phase; elsewhere it rests visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt  <= '0;
      blink_dark <= 1'b0;
    end else if (select == SEL_RESULT) begin
      if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
        blink_cnt  <= '0;
        blink_dark <= ~blink_dark;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      blink_cnt  <= '0;
      blink_dark <= 1'b0;
    end
  end

  // Glyph and anode selection for the digit currently being scanned.
  always_comb begin
    nibble       = disp[{index, 2'b00} +: 4];
    leading_zero = 1'b0;
    glyph_next   = GLYPH_BLANK;
    case (index)
      2'd3:    leading_zero = (disp[15:12] == 4'd0);
      2'd2:    leading_zero = (disp[15:8] == 8'd0);
      2'd1:    leading_zero = (disp[15:4] == 12'd0);
      default: leading_zero = 1'b0;
    endcase
    if (select == SEL_MODE) begin
      if (index == 2'd0) begin
        case (mode)
          2'd0:    glyph_next = GLYPH_E;
          2'd1:    glyph_next = GLYPH_N;
          2'd2:    glyph_next = GLYPH_H;
          default: glyph_next = GLYPH_DASH;
        endcase
      end
    end else if (disp_ovf) begin
      glyph_next = GLYPH_DASH;
    end else if (!leading_zero) begin
      glyph_next = digit_glyph(nibble);
    end
    an_next = ~(4'b0001 << index);
    if ((select == SEL_RESULT) && blink_dark) an_next = 4'b1111;
  end

  // Register anodes and cathodes together so they always agree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= GLYPH_BLANK;
    end else begin
      an  <= an_next;
      seg <= glyph_next;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver with short refresh/blink periods.
module tb_seg_display_driver;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  select;
  logic [1:0]  mode;
  logic [13:0] number;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  bit blink_q[$];

  seg_display_driver #(
    .REFRESH_TICKS (4),
    .BLINK_TICKS   (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .select (select),
    .mode   (mode),
    .number (number),
    .seg    (seg),
    .dp     (dp),
    .an     (an)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] an_code(input int k);
    logic [3:0] a;
    case (k)
      0:       a = 4'b1110;
      1:       a = 4'b1101;
      2:       a = 4'b1011;
      default: a = 4'b0111;
    endcase
    return a;
  endfunction

  function automatic logic [6:0] dec_glyph(input int d);
    logic [6:0] g;
    case (d)
      0:       g = 7'b1000000;
      1:       g = 7'b1111001;
      2:       g = 7'b0100100;
      3:       g = 7'b0110000;
      4:       g = 7'b0011001;
      5:       g = 7'b0010010;
      6:       g = 7'b0000010;
      7:       g = 7'b1111000;
      8:       g = 7'b0000000;
      default: g = 7'b0010000;
    endcase
    return g;
  endfunction

  // Reference rendering of one decimal digit position for a value.
  function automatic logic [6:0] model_glyph(input int v, input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (v > 9999) return 7'b0111111;
    if (k > 0 && v < p) return 7'b1111111;
    return dec_glyph((v / p) % 10);
  endfunction

  task automatic push_number(input int v);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.an  = an_code(k);
      e.seg = model_glyph(v, k);
      exp_q.push_back(e);
    end
  endtask

  // Wait (bounded) for a digit to be selected and report its glyph and dwell.
  task automatic capture_digit(input logic [3:0] target, input bit sync,
                               output logic [6:0] seg_obs, output int dwell,
                               output bit tmo);
    int n;
    tmo = 1'b0;
    dwell = 0;
    seg_obs = 7'h7f;
    n = 0;
    if (sync) begin
      while (an === target && n < 64) begin
        @(negedge clk);
        n++;
      end
    end
    n = 0;
    while (an !== target && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (an !== target) begin
      tmo = 1'b1;
    end else begin
      seg_obs = seg;
      while (an === target && dwell < 64) begin
        dwell++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    select = 2'd1;
    mode   = 2'd0;
    number = 14'd0;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    number = 14'd1234;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL reset_an got %b exp %b", an, 4'b1111);
    end
    checks++;
    if (seg !== 7'b1111111) begin
      errors++;
      $display("[TB] FAIL reset_seg got %b exp %b", seg, 7'b1111111);
    end
    checks++;
    if (dp !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_dp got %b exp 1", dp);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (an !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL first_an got %b exp %b", an, 4'b1110);
    end
    checks++;
    if (seg !== 7'b1000000) begin
      errors++;
      $display("[TB] FAIL first_seg got %b exp %b", seg, 7'b1000000);
    end
    @(negedge clk);
  endtask

  task automatic test_full_scan;
    int vals[3];
    exp_t e;
    logic [6:0] s;
    int dwell;
    bit tmo;
    bit first;
    vals[0] = 1234;
    vals[1] = int'($urandom_range(1000, 9999));
    vals[2] = int'($urandom_range(0, 999));
    select = 2'd1;
    foreach (vals[i]) begin
      number = 14'(vals[i]);
      repeat (40) @(negedge clk);
      push_number(vals[i]);
      first = 1'b1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        capture_digit(e.an, first, s, dwell, tmo);
        checks++;
        if (tmo) begin
          errors++;
          $display("[TB] FAIL scan_timeout value %0d an %b never selected", vals[i], e.an);
        end else if (s !== e.seg) begin
          errors++;
          $display("[TB] FAIL scan_seg value %0d an %b got %b exp %b", vals[i], e.an, s, e.seg);
        end
        checks++;
        if (!tmo && dwell != 4) begin
          errors++;
          $display("[TB] FAIL scan_dwell value %0d an %b got %0d exp 4", vals[i], e.an, dwell);
        end
        first = 1'b0;
      end
    end
  endtask

  task automatic test_leading_zero;
    int vals[4];
    exp_t e;
    logic [6:0] s;
    int dwell;
    bit tmo;
    bit first;
    vals[0] = 7;
    vals[1] = 0;
    vals[2] = 80;
    vals[3] = 305;
    select = 2'd3;
    foreach (vals[i]) begin
      number = 14'(vals[i]);
      repeat (40) @(negedge clk);
      push_number(vals[i]);
      first = 1'b1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        capture_digit(e.an, first, s, dwell, tmo);
        checks++;
        if (tmo) begin
          errors++;
          $display("[TB] FAIL lz_timeout value %0d an %b never selected", vals[i], e.an);
        end else if (s !== e.seg) begin
          errors++;
          $display("[TB] FAIL lz_seg value %0d an %b got %b exp %b", vals[i], e.an, s, e.seg);
        end
        first = 1'b0;
      end
    end
  endtask

  task automatic test_overflow;
    int vals[5];
    exp_t e;
    logic [6:0] s;
    int dwell;
    bit tmo;
    bit first;
    vals[0] = 9999;
    vals[1] = 10000;
    vals[2] = 12000;
    vals[3] = 16383;
    vals[4] = 9998;
    select = 2'd1;
    foreach (vals[i]) begin
      number = 14'(vals[i]);
      repeat (34) @(negedge clk);
      push_number(vals[i]);
      first = 1'b1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        capture_digit(e.an, first, s, dwell, tmo);
        checks++;
        if (tmo) begin
          errors++;
          $display("[TB] FAIL ovf_timeout value %0d an %b never selected", vals[i], e.an);
        end else if (s !== e.seg) begin
          errors++;
          $display("[TB] FAIL ovf_seg value %0d an %b got %b exp %b", vals[i], e.an, s, e.seg);
        end
        first = 1'b0;
      end
    end
  endtask

  task automatic test_mode_letters;
    logic [6:0] letters[4];
    exp_t e;
    logic [6:0] s;
    int dwell;
    bit tmo;
    bit first;
    letters[0] = 7'b0000110;
    letters[1] = 7'b0101011;
    letters[2] = 7'b0001001;
    letters[3] = 7'b0111111;
    number = 14'd5678;
    select = 2'd0;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        e.an  = an_code(k);
        e.seg = (k == 0) ? letters[m] : 7'b1111111;
        exp_q.push_back(e);
      end
      first = 1'b1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        capture_digit(e.an, first, s, dwell, tmo);
        checks++;
        if (tmo) begin
          errors++;
          $display("[TB] FAIL mode_timeout mode %0d an %b never selected", m, e.an);
        end else if (s !== e.seg) begin
          errors++;
          $display("[TB] FAIL mode_seg mode %0d an %b got %b exp %b", m, e.an, s, e.seg);
        end
        first = 1'b0;
      end
    end
  endtask

  task automatic test_blink;
    bit exp_dark;
    bit obs_dark;
    int bad;
    select = 2'd1;
    number = 14'd42;
    repeat (40) @(negedge clk);
    select = 2'd2;
    for (int k = 1; k <= 56; k++) blink_q.push_back((((k - 1) / 16) % 2) == 1);
    bad = 0;
    for (int k = 1; k <= 56; k++) begin
      @(negedge clk);
      exp_dark = blink_q.pop_front();
      obs_dark = (an === 4'b1111);
      checks++;
      if (obs_dark !== exp_dark) begin
        errors++;
        bad++;
        if (bad <= 8) $display("[TB] FAIL blink_phase cycle %0d got dark=%0b exp dark=%0b", k, obs_dark, exp_dark);
      end
    end
    select = 2'd0;
    @(negedge clk);
    checks++;
    if (an === 4'b1111 || $countones(~an) != 1) begin
      errors++;
      $display("[TB] FAIL blink_exit_an got %b exp one active anode", an);
    end
  endtask

  initial begin
    rst    = 1'b1;
    select = 2'd1;
    mode   = 2'd0;
    number = 14'd0;
    test_reset();
    test_full_scan();
    test_leading_zero();
    test_overflow();
    test_mode_letters();
    test_blink();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
